// File: rtl/ifid_pkg.sv
// ifid_pkg: shared default widths, NOP encoding and payload layout for the IF/ID stage
package ifid_pkg;

    localparam int INSTR_W_DEF = 16;
    localparam int PC_W_DEF    = 16;
    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = 16'h0800;

    // Payload layout at default widths; instr sits in the upper bits, pc_inc in the lower bits
    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [PC_W_DEF-1:0]    pc_inc;
    } ifid_payload_t;

endpackage

// File: rtl/ifid_pipe_stage_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear wins over increment; the count sticks at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != {W{1'b1}})
            count <= count + 1'b1;
    end

endmodule

// File: rtl/ifid_pipe_stage.sv
// ifid_pipe_stage: IF/ID register with valid/ready handshake, optional skid entry, flush-to-NOP and perf counters
module ifid_pipe_stage
    import ifid_pkg::*;
#(
    parameter int               INSTR_W   = INSTR_W_DEF,
    parameter int               PC_W      = PC_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
    parameter bit               SKID      = 1'b1,
    parameter int               CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc_inc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc_inc,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam int P_W = INSTR_W + PC_W;
    localparam logic [P_W-1:0] NOP_WORD = {NOP_INSTR, {PC_W{1'b0}}};

    logic [P_W-1:0] out_q;
    logic [P_W-1:0] skid_q;
    logic           skid_full;
    logic           in_fire;
    logic           out_fire;
    logic           take;

    // With a skid entry in_ready is purely registered; without one it looks through to out_ready
    assign in_ready = SKID ? ~skid_full : (out_ready | ~out_valid);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign take     = ~out_valid | out_fire;
    assign {out_instr, out_pc_inc} = out_q;

    // Flush squashes everything; a free output refills from skid first, a held output spills the input into skid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= NOP_WORD;
            skid_full <= 1'b0;
            skid_q    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_q     <= NOP_WORD;
            skid_full <= 1'b0;
        end else if (take) begin
            out_valid <= skid_full | in_fire;
            skid_full <= 1'b0;
            if (skid_full)
                out_q <= skid_q;
            else if (in_fire)
                out_q <= {in_instr, in_pc_inc};
        end else if (SKID && in_fire) begin
            skid_full <= 1'b1;
            skid_q    <= {in_instr, in_pc_inc};
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (~out_valid),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_ifid_pipe_stage.sv
// tb_ifid_pipe_stage: randomized check of three stage builds against a FIFO-level reference model
module tb_ifid_pipe_stage;

    localparam logic [31:0] NOP_WORD = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic        cnt_clr;
    logic [15:0] in_instr;
    logic [15:0] in_pc_inc;
    logic        ov [3];
    logic        ir [3];
    logic [15:0] oi [3];
    logic [15:0] op [3];
    logic [15:0] sc [3];
    logic [15:0] bc [3];
    logic [2:0]  sc3;
    logic [2:0]  bc3;

    int checks = 0;
    int failures = 0;

    int          n    [3];
    logic [31:0] mq   [3][2];
    logic [31:0] last [3];
    int          stl  [3];
    int          bub  [3];

    always #5 clk = ~clk;

    assign sc[2] = {13'b0, sc3};
    assign bc[2] = {13'b0, bc3};

    ifid_pipe_stage #(.SKID(1'b1)) u_skid (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_instr(in_instr),
        .in_pc_inc(in_pc_inc), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
        .out_instr(oi[0]), .out_pc_inc(op[0]), .cnt_clr(cnt_clr), .stall_cnt(sc[0]), .bubble_cnt(bc[0])
    );

    ifid_pipe_stage #(.SKID(1'b0)) u_reg (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_instr(in_instr),
        .in_pc_inc(in_pc_inc), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
        .out_instr(oi[1]), .out_pc_inc(op[1]), .cnt_clr(cnt_clr), .stall_cnt(sc[1]), .bubble_cnt(bc[1])
    );

    ifid_pipe_stage #(.SKID(1'b1), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_instr(in_instr),
        .in_pc_inc(in_pc_inc), .flush(flush), .out_valid(ov[2]), .out_ready(out_ready),
        .out_instr(oi[2]), .out_pc_inc(op[2]), .cnt_clr(cnt_clr), .stall_cnt(sc3), .bubble_cnt(bc3)
    );

    function automatic int cmax(int k);
        return k == 2 ? 7 : 65535;
    endfunction

    function automatic bit has_skid(int k);
        return k != 1;
    endfunction

    function automatic bit m_ready(int k);
        return has_skid(k) ? (n[k] < 2) : (n[k] == 0 || out_ready);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            n[k]    = 0;
            last[k] = NOP_WORD;
            stl[k]  = 0;
            bub[k]  = 0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("out_valid%0d", k), {31'b0, ov[k]}, {31'b0, n[k] > 0});
            chk($sformatf("in_ready%0d", k), {31'b0, ir[k]}, {31'b0, m_ready(k)});
            chk($sformatf("payload%0d", k), {oi[k], op[k]}, n[k] > 0 ? mq[k][0] : last[k]);
            chk($sformatf("stall_cnt%0d", k), {16'b0, sc[k]}, stl[k]);
            chk($sformatf("bubble_cnt%0d", k), {16'b0, bc[k]}, bub[k]);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            bit v, fi, fo;
            v  = n[k] > 0;
            fi = in_valid && m_ready(k);
            fo = v && out_ready;
            if (cnt_clr) begin
                stl[k] = 0;
                bub[k] = 0;
            end else begin
                if (v && !out_ready && stl[k] < cmax(k)) stl[k]++;
                if (!v && bub[k] < cmax(k)) bub[k]++;
            end
            if (flush) begin
                n[k]    = 0;
                last[k] = NOP_WORD;
            end else begin
                if (fo) begin
                    last[k]  = mq[k][0];
                    mq[k][0] = mq[k][1];
                    n[k]--;
                end
                if (fi) begin
                    mq[k][n[k]] = {in_instr, in_pc_inc};
                    n[k]++;
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        in_instr  = '0;
        in_pc_inc = '0;
        model_reset();
        @(negedge clk);
        #1 check_all();
        rst = 1'b0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            int ph;
            if (cyc == 600) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_all();
                @(negedge clk);
                rst = 1'b0;
            end
            ph        = (cyc / 50) % 4;
            in_valid  = $urandom_range(9) < (ph == 0 ? 9 : 6);
            in_instr  = 16'($urandom);
            in_pc_inc = 16'($urandom);
            out_ready = ph == 0 ? 1'b1 :
                        ph == 1 ? ($urandom_range(9) < 4) :
                        ph == 2 ? ((cyc % 25) >= 14) : 1'($urandom_range(1));
            flush     = $urandom_range(29) == 0;
            cnt_clr   = $urandom_range(59) == 0;
            #1 check_all();
            model_step();
            @(negedge clk);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
